uart_rx: RTL and testbench

Serial-to-parallel UART receiver: 8N1 frames, LSB first. It is the receive-side counterpart of the PeriPlex UART transmitter and shares the same run-time baud configuration word (clocks per bit). It sits between the external RX pin and the APB UART register/FIFO logic. It presents each received byte with a one-cycle valid strobe and flags framing errors.

---
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, run-time clocks-per-bit, framing-error strobe.
module uart_rx #(
    parameter int UART_DATA_WIDTH   = 8,
    parameter int CONFIG_DATA_WIDTH = 32
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic [CONFIG_DATA_WIDTH-1:0] uart_config_data,
    input  logic                         i_Rx_Serial,
    output logic                         o_Rx_DV,
    output logic [UART_DATA_WIDTH-1:0]   o_Rx_Byte,
    output logic                         o_Rx_Active,
    output logic                         o_Rx_Frame_Err
);
    localparam int IW = $clog2(UART_DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, WAIT_IDLE} state_t;
    state_t state_q, state_d;
    logic meta_q, rx_s_q;
    logic [CONFIG_DATA_WIDTH-1:0] cfg_q, cfg_d, cnt_q, cnt_d, half;
    logic [IW-1:0] idx_q, idx_d;
    logic [UART_DATA_WIDTH-1:0] shift_q, shift_d, byte_q, byte_d;
    logic dv_q, dv_d, err_q, err_d, active_q, active_d;
    logic cnt_done;

    assign half     = cfg_q >> 1;
    assign cnt_done = cnt_q == cfg_q;

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                cfg_d    = (uart_config_data < CONFIG_DATA_WIDTH'(4)) ? CONFIG_DATA_WIDTH'(3)
                                                                     : uart_config_data - CONFIG_DATA_WIDTH'(1);
                cnt_d    = '0;
                idx_d    = '0;
                active_d = !rx_s_q;
                state_d  = rx_s_q ? IDLE : START;
            end
            START: begin
                cnt_d = cnt_q + CONFIG_DATA_WIDTH'(1);
                if (cnt_q == half) begin
                    cnt_d    = '0;
                    active_d = !rx_s_q;
                    state_d  = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CONFIG_DATA_WIDTH'(1);
                if (cnt_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + IW'(1);
                    state_d        = (idx_q == IW'(UART_DATA_WIDTH - 1)) ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_d = cnt_q + CONFIG_DATA_WIDTH'(1);
                if (cnt_done) begin
                    cnt_d   = '0;
                    byte_d  = rx_s_q ? shift_q : byte_q;
                    dv_d    = rx_s_q;
                    err_d   = !rx_s_q;
                    state_d = rx_s_q ? CLEANUP : WAIT_IDLE;
                end
            end
            CLEANUP: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
            WAIT_IDLE: begin
                // a held-low line must release before another start bit is honoured
                active_d = !rx_s_q;
                state_d  = rx_s_q ? IDLE : WAIT_IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            state_q  <= IDLE;
            cfg_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            meta_q   <= i_Rx_Serial;
            rx_s_q   <= meta_q;
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a byte/error scoreboard checked by an independent monitor.
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg = 32'd16;
    logic        rx  = 1'b1;
    logic        dv, act, ferr;
    logic [7:0]  rbyte;
    int          checks = 0;
    int          failures = 0;
    int          err_exp = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    uart_rx dut (
        .i_Clock(clk), .i_Reset(rst), .uart_config_data(cfg), .i_Rx_Serial(rx),
        .o_Rx_DV(dv), .o_Rx_Byte(rbyte), .o_Rx_Active(act), .o_Rx_Frame_Err(ferr)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dv && ferr) check("dv_err_exclusive", 1, 0);
            if (dv) begin
                if (exp_q.size() == 0) check("unexpected_dv", {24'd0, rbyte}, 32'hffff_ffff);
                else check("rx_byte", {24'd0, rbyte}, {24'd0, exp_q.pop_front()});
            end
            if (ferr) begin
                check("frame_err_expected", err_exp, 1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    task automatic frame(input logic [7:0] b, input logic stop, input int n);
        if (stop) exp_q.push_back(b);
        else err_exp++;
        rx = 1'b0;
        repeat (n) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (n) @(posedge clk);
        end
        rx = stop;
        repeat (n) @(posedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_dv"}, dv, 0);
        check({name, "_byte"}, rbyte, 0);
        check({name, "_act"}, act, 0);
        check({name, "_err"}, ferr, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);

        fork
            frame(8'hA5, 1'b1, 16);
            begin
                repeat (60) @(negedge clk);
                check("basic_active_mid", act, 1);
            end
        join
        drain("basic_drain");
        check("basic_active_after", act, 0);
        check("basic_byte_held", rbyte, 8'hA5);

        frame(8'h00, 1'b1, 16);
        frame(8'hFF, 1'b1, 16);
        frame(8'h55, 1'b1, 16);
        rx = 1'b1;
        drain("b2b_drain");

        rx = 1'b0;
        repeat (5) @(posedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_active", act, 0);
        repeat (50) @(negedge clk);

        frame(8'h3C, 1'b0, 16);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("ferr_seen", err_exp, 0);
        check("ferr_byte_hold", rbyte, 8'h55);
        check("ferr_active_held", act, 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_active_release", act, 0);
        repeat (20) @(posedge clk);
        frame(8'h3C, 1'b1, 16);
        rx = 1'b1;
        drain("ferr_recover_drain");

        cfg = 32'd437;
        repeat (3) @(posedge clk);
        fork
            frame(8'h81, 1'b1, 437);
            begin
                repeat (437 * 4) @(posedge clk);
                cfg = 32'd16;
            end
        join
        rx = 1'b1;
        drain("slow_drain");
        cfg = 32'd2;
        repeat (3) @(posedge clk);
        frame(8'h7E, 1'b1, 4);
        rx = 1'b1;
        drain("clamp_drain");

        cfg = 32'd16;
        repeat (3) @(posedge clk);
        rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (16) @(posedge clk);
        end
        rx = 1'b0;
        repeat (8) @(posedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("midreset_idle", act, 0);
        frame(8'h96, 1'b1, 16);
        rx = 1'b1;
        drain("midreset_recover_drain");
        check("final_err_pending", err_exp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
